// File: rtl/pixel_writer_pkg.sv
// Shared definitions for the pixel writer: command codes, FSM states and
// the command/bpp classification helpers.
package pixel_writer_pkg;

  localparam logic [3:0] CMD_NOP           = 4'd0;
  localparam logic [3:0] CMD_PXWRI         = 4'd1;
  localparam logic [3:0] CMD_PXWRI_M       = 4'd2;
  localparam logic [3:0] CMD_PXPASTE       = 4'd3;
  localparam logic [3:0] CMD_PXPASTE_M     = 4'd4;
  localparam logic [3:0] CMD_PXCOPY        = 4'd6;
  localparam logic [3:0] CMD_SETARGB       = 4'd7;
  localparam logic [3:0] CMD_RST_PXWRI_M   = 4'd10;
  localparam logic [3:0] CMD_RST_PXPASTE_M = 4'd11;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RD_REQ,
    ST_RD_WAIT,
    ST_WR_REQ
  } state_t;

  // Pixel widths of 1, 2, 4, 8 and 16 bits tile a 16-bit word exactly
  function automatic logic bpp_valid(input logic [3:0] b);
    return (b == 4'd0) || (b == 4'd1) || (b == 4'd3) || (b == 4'd7) || (b == 4'd15);
  endfunction

  function automatic logic is_mem_cmd(input logic [3:0] c);
    return (c == CMD_PXWRI) || (c == CMD_PXWRI_M) || (c == CMD_PXPASTE) ||
           (c == CMD_PXPASTE_M) || (c == CMD_PXCOPY);
  endfunction

endpackage

// File: rtl/pixel_field_merge.sv
// Locates one MSB-first packed pixel inside a 16-bit word, extracts the
// existing value and merges a new source value into it.
module pixel_field_merge (
  input  logic [3:0]  bpp,
  input  logic [3:0]  pix,
  input  logic [15:0] rd_word,
  input  logic [15:0] src,
  output logic [15:0] existing,
  output logic [15:0] merged
);

  logic [3:0]  width;
  logic [3:0]  offset;
  logic [3:0]  shift;
  logic [15:0] mask;

  always_comb begin
    // width wraps to 0 for bpp=15; offset only matters mod 16, so that is harmless
    width    = bpp + 4'd1;
    offset   = pix * width;
    shift    = 4'd15 - bpp - offset;
    mask     = (16'hFFFF >> (4'd15 - bpp)) << shift;
    existing = (rd_word & mask) >> shift;
    merged   = (rd_word & ~mask) | ((src << shift) & mask);
  end

endmodule

// File: rtl/pixel_writer.sv
// Pixel writer: read-modify-write of one graphics memory word per pixel
// command, plus transparency key, copy buffer and collision counters.
module pixel_writer
  import pixel_writer_pkg::*;
#(
  parameter int ADDR_BITS = 20,
  parameter int CNT_BITS  = 8
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 pixel_cmd_rdy,
  input  logic [39:0]          pixel_cmd,
  output logic                 draw_busy,
  output logic                 mem_req,
  output logic                 mem_wr,
  output logic [ADDR_BITS-1:0] mem_addr,
  output logic [15:0]          mem_wdata,
  input  logic                 mem_ack,
  input  logic                 mem_rd_valid,
  input  logic [15:0]          mem_rd_data,
  output logic [CNT_BITS-1:0]  wri_collision,
  output logic [CNT_BITS-1:0]  paste_collision
);

  state_t                 state, state_nxt;
  logic [3:0]             cmd_q, bpp_q, pix_q;
  logic [7:0]             colour_q, key_q, copy_q;
  logic [ADDR_BITS-1:1]   addr_q;
  logic [15:0]            wdata_q, src, existing, merged;
  logic [3:0]             cmd_in;
  logic                   accept, go_mem, rd_done, hit;

  assign cmd_in = pixel_cmd[39:36];

  always_comb begin
    accept  = pixel_cmd_rdy && (state == ST_IDLE);
    // a keyed paste of a transparent copy completes without touching memory
    go_mem  = accept && is_mem_cmd(cmd_in) && bpp_valid(pixel_cmd[27:24]) &&
              !((cmd_in == CMD_PXPASTE_M) && (copy_q == key_q));
    rd_done = (state == ST_RD_WAIT) && mem_rd_valid;
    src     = ((cmd_q == CMD_PXPASTE) || (cmd_q == CMD_PXPASTE_M)) ?
              {8'h00, copy_q} : {8'h00, colour_q};
    hit     = (existing != 16'h0000);
  end

  pixel_field_merge u_merge (
    .bpp      (bpp_q),
    .pix      (pix_q),
    .rd_word  (mem_rd_data),
    .src      (src),
    .existing (existing),
    .merged   (merged)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= ST_IDLE;
      draw_busy <= 1'b0;
    end else begin
      state     <= state_nxt;
      draw_busy <= (state_nxt != ST_IDLE);
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:    if (go_mem)       state_nxt = ST_RD_REQ;
      ST_RD_REQ:  if (mem_ack)      state_nxt = ST_RD_WAIT;
      ST_RD_WAIT: if (mem_rd_valid) state_nxt = (cmd_q == CMD_PXCOPY) ? ST_IDLE : ST_WR_REQ;
      ST_WR_REQ:  if (mem_ack)      state_nxt = ST_IDLE;
      default:                      state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    mem_req = (state == ST_RD_REQ) || (state == ST_WR_REQ);
    mem_wr  = (state == ST_WR_REQ);
  end

  assign mem_addr  = {addr_q, 1'b0};
  assign mem_wdata = wdata_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cmd_q           <= '0;
      bpp_q           <= '0;
      pix_q           <= '0;
      colour_q        <= '0;
      addr_q          <= '0;
      key_q           <= '0;
      copy_q          <= '0;
      wdata_q         <= '0;
      wri_collision   <= '0;
      paste_collision <= '0;
    end else begin
      if (accept) begin
        cmd_q    <= cmd_in;
        colour_q <= pixel_cmd[35:28];
        bpp_q    <= pixel_cmd[27:24];
        pix_q    <= pixel_cmd[23:20];
        addr_q   <= pixel_cmd[ADDR_BITS-1:1];
        case (cmd_in)
          CMD_SETARGB:       key_q           <= pixel_cmd[7:0];
          CMD_RST_PXWRI_M:   wri_collision   <= '0;
          CMD_RST_PXPASTE_M: paste_collision <= '0;
          default: ;
        endcase
      end
      if (rd_done) begin
        if (cmd_q == CMD_PXCOPY) copy_q  <= existing[7:0];
        else                     wdata_q <= merged;
        if (hit && (cmd_q == CMD_PXWRI_M) && (wri_collision != '1))
          wri_collision <= wri_collision + 1'b1;
        if (hit && (cmd_q == CMD_PXPASTE_M) && (paste_collision != '1))
          paste_collision <= paste_collision + 1'b1;
      end
    end
  end

endmodule

// File: doc/pixel_writer.md
Name: pixel_writer

Overview:
- Downstream of the pixel address generator; consumes its 40-bit pixel commands.
- Performs a read-modify-write of one 16-bit word in graphics memory per pixel write, or a read for pixel copy.
- Maintains the transparency key, a one-pixel copy buffer and two collision counters.
- Drives draw_busy back upstream to stall the address generator.

Parameters:
- ADDR_BITS, 20, memory word-address width (pixel_cmd[19:0]).
- CNT_BITS, 8, width of each collision counter.

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous, active-low reset
- pixel_cmd_rdy  in  1  one-cycle strobe; pixel_cmd valid (upstream already gates it with !draw_busy)
- pixel_cmd  in  40  [39:36] cmd, [35:28] colour, [27:24] bpp code, [23:20] pixel index, [19:0] address
- draw_busy  out  1  high while a memory command is in progress
- mem_req  out  1  memory request, held until mem_ack
- mem_wr  out  1  1 = write, 0 = read; valid with mem_req
- mem_addr  out  ADDR_BITS  word address; bit0 forced 0
- mem_wdata  out  16  write data
- mem_ack  in  1  request accepted this cycle
- mem_rd_valid  in  1  read data valid; arrives no earlier than the cycle after the read's mem_ack
- mem_rd_data  in  16  read word
- wri_collision  out  CNT_BITS  PXWRI_M collision count
- paste_collision  out  CNT_BITS  PXPASTE_M collision count

Behaviour:
- Reset: all outputs 0; state IDLE; key, copy buffer and counters 0. Reset mid-operation aborts the command and drops mem_req immediately.
- Accept rule: a command is accepted on any cycle with pixel_cmd_rdy in IDLE, and pixel_cmd is registered on that edge. pixel_cmd_rdy outside IDLE is ignored; upstream guarantees this cannot happen.
- Commands 1, 2, 3, 4, 6 are memory commands; draw_busy is registered and equals state != IDLE.
- Immediate commands, completed in the accept cycle with no busy:
  - SETARGB (7): key <= pixel_cmd[7:0].
  - RST_PXWRI_M (10): clear wri_collision.
  - RST_PXPASTE_M (11): clear paste_collision.
  - NOP and other codes: ignored.
- Invalid bpp: memory commands with a bpp code outside {0,1,3,7,15} are dropped with no memory access.
- Pixel field, with b = bpp code and p = pixel index:
  - width b+1
  - shift = (15-b) - ((p*(b+1)) & 15); pixels are packed MSB-first
  - mask = ((1<<(b+1))-1) << shift
  - For b=15, colour is zero-extended to 16 bits.
- FSM states: IDLE -> RD_REQ -> RD_WAIT -> (WR_REQ | IDLE).
  - RD_REQ: mem_req=1, mem_wr=0; advance to RD_WAIT on mem_ack.
  - RD_WAIT: on mem_rd_valid, compute the merge and existing pixel e = (rd & mask) >> shift.
    - PXCOPY (6): copy <= e[7:0]; go to IDLE.
    - Write commands: register merged word new = (rd & ~mask) | ((src << shift) & mask); go to WR_REQ.
  - WR_REQ: mem_req=1, mem_wr=1, mem_wdata=new; go to IDLE on mem_ack.
- Write source: src = colour for PXWRI and PXWRI_M; src = copy for PXPASTE and PXPASTE_M.
- PXWRI_M: if e != 0, wri_collision increments and saturates at all-ones; the write always happens.
- PXPASTE_M: if copy == key, the command completes in the accept cycle with no memory access and no busy. Otherwise it behaves as PXPASTE, and paste_collision increments (saturating) when e != 0.
- Minimum latency with mem_ack same cycle and rd_valid one cycle later:
  - write: accept T; RD_REQ T+1; rd_valid T+2; WR_REQ T+3; IDLE T+4.
  - copy: IDLE at T+3.
- mem_addr, mem_wr and mem_wdata are stable while mem_req=1 and mem_ack=0.
- Simultaneous SETARGB and completion of a PXPASTE_M is impossible because acceptance is IDLE-only. A counter reset and an increment cannot coincide for the same reason.

Decomposition:
- Package pixel_writer_pkg: command code localparams (NOP 0, PXWRI 1, PXWRI_M 2, PXPASTE 3, PXPASTE_M 4, PXCOPY 6, SETARGB 7, RST_PXWRI_M 10, RST_PXPASTE_M 11), the FSM state enum, and the valid bpp codes.
- Sub-module pixel_field_merge: purely combinational (b, p, rd word, src) -> (mask, shift, existing pixel, merged word). It is shared by the FSM and the testbench model.

Test Plan:
- PXWRI, b=7, p=1, colour 0xAB, addr 0x00100, memory returns 0x1234 -> read at 0x00100, then write 0x12AB at 0x00100; draw_busy high for exactly T+1..T+3.
- PXWRI, b=0, p=0, colour 0x01, memory 0x0000 -> write 0x8000; with b=0, p=15 -> write 0x0001.
- PXCOPY, b=3, p=2, memory 0x1234 -> no write, copy=0x3; then PXPASTE, b=3, p=0 on 0x0000 -> write 0x3000.
- SETARGB key 0x03, then PXPASTE_M with copy=0x3 -> no mem_req, draw_busy stays 0. With key 0x00 and existing pixel 0x5 -> write occurs and paste_collision=1. Then RST_PXPASTE_M -> 0.
- PXWRI_M repeated 300 times over non-zero pixels -> wri_collision saturates at 255; mem_ack delayed 5 cycles -> mem_req, addr and wdata held stable throughout.
- Assert reset_n low during WR_REQ -> mem_req, draw_busy and counters 0 immediately; the next command after release behaves normally.
